// File: rtl/detector_colisiones.sv
// Collision / scoring / bonus detector for the runner game.
// Watches the obstacle scroll tick, evaluates the hero against the obstacle
// two clock cycles later, and keeps lives, score, bonus progress and the
// win/lose verdict. All outputs are registered.
module detector_colisiones #(
    parameter logic [2:0] GAME       = 3'd3,
    parameter logic [1:0] VIDAS_INI  = 2'd3,
    parameter int         INVULN     = 2,
    parameter logic [1:0] BONOS_META = 2'd3,
    parameter int         BONO_PULSO = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] presente,
    input  logic       clk_obstaculos,
    input  logic [6:0] display_obs,
    input  logic [4:0] tipo_obs,
    input  logic [6:0] heroe,
    input  logic       accion,
    output logic [1:0] W_or_L,
    output logic       bono_tomado,
    output logic [1:0] vidas,
    output logic [7:0] puntaje
);

    localparam int INV_W = (INVULN < 1) ? 1 : $clog2(INVULN + 1);
    localparam int PUL_W = (BONO_PULSO < 2) ? 1 : $clog2(BONO_PULSO);

    localparam logic [INV_W-1:0] INV_LOAD  = INV_W'(INVULN);
    localparam logic [PUL_W-1:0] PUL_LOAD  = PUL_W'(BONO_PULSO - 1);
    localparam logic [4:0]       TIPO_BONO = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_INV  = 3'd2,
        S_WIN  = 3'd3,
        S_LOSE = 3'd4
    } estado_t;

    estado_t          estado_q;
    logic             clk_obs_q;
    logic [1:0]       eval_q;
    logic [1:0]       vidas_q;
    logic [7:0]       puntaje_q;
    logic [1:0]       bonos_q;
    logic [INV_W-1:0] inv_q;
    logic [PUL_W-1:0] pulso_q;
    logic             bono_q;
    logic [1:0]       wl_q;

    logic             tick_s;
    logic             en_juego_s;
    logic             eval_s;
    logic             colision_s;
    logic             bono_s;
    logic [1:0]       vidas_d;
    logic [7:0]       puntaje_d;
    logic [1:0]       bonos_d;
    logic [INV_W-1:0] inv_d;

    // Tick strobe, evaluation qualifiers and the candidate updated counters.
    always_comb begin
        tick_s     = clk_obstaculos & ~clk_obs_q;
        en_juego_s = (estado_q == S_PLAY) || (estado_q == S_INV);
        eval_s     = eval_q[1] & en_juego_s;
        // Collisions are only checked outside the invulnerability window.
        colision_s = (estado_q == S_PLAY) && ((display_obs & heroe) != 7'd0);
        bono_s     = !colision_s && (tipo_obs == TIPO_BONO) && accion;
        bonos_d    = bonos_q + 2'd1;

        if (vidas_q != 2'd0) begin
            vidas_d = vidas_q - 2'd1;
        end else begin
            vidas_d = 2'd0;
        end

        if ((display_obs != 7'd0) && (puntaje_q != 8'hFF)) begin
            puntaje_d = puntaje_q + 8'd1;
        end else begin
            puntaje_d = puntaje_q;
        end

        if (inv_q != {INV_W{1'b0}}) begin
            inv_d = inv_q - {{(INV_W-1){1'b0}}, 1'b1};
        end else begin
            inv_d = {INV_W{1'b0}};
        end
    end

    // Game FSM with tick pipeline, bonus pulse stretcher and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= S_IDLE;
            clk_obs_q <= 1'b0;
            eval_q    <= 2'b00;
            vidas_q   <= VIDAS_INI;
            puntaje_q <= 8'd0;
            bonos_q   <= 2'd0;
            inv_q     <= {INV_W{1'b0}};
            pulso_q   <= {PUL_W{1'b0}};
            bono_q    <= 1'b0;
            wl_q      <= 2'b00;
        end else if (presente != GAME) begin
            // Leaving the game abandons everything, including pending evaluations.
            estado_q  <= S_IDLE;
            clk_obs_q <= clk_obstaculos;
            eval_q    <= 2'b00;
            vidas_q   <= VIDAS_INI;
            puntaje_q <= 8'd0;
            bonos_q   <= 2'd0;
            inv_q     <= {INV_W{1'b0}};
            pulso_q   <= {PUL_W{1'b0}};
            bono_q    <= 1'b0;
            wl_q      <= 2'b00;
        end else begin
            clk_obs_q <= clk_obstaculos;
            // Only ticks seen while actually playing lead to an evaluation.
            eval_q    <= {eval_q[0], tick_s & en_juego_s};

            // A new bonus restarts the pulse; otherwise it runs to completion
            // regardless of the game state.
            if (eval_s && bono_s) begin
                bono_q  <= 1'b1;
                pulso_q <= PUL_LOAD;
            end else if (pulso_q != {PUL_W{1'b0}}) begin
                pulso_q <= pulso_q - {{(PUL_W-1){1'b0}}, 1'b1};
            end else begin
                bono_q  <= 1'b0;
            end

            case (estado_q)
                S_IDLE: begin
                    estado_q  <= S_PLAY;
                    vidas_q   <= VIDAS_INI;
                    puntaje_q <= 8'd0;
                    bonos_q   <= 2'd0;
                    inv_q     <= {INV_W{1'b0}};
                    wl_q      <= 2'b00;
                end
                S_PLAY, S_INV: begin
                    if (eval_s) begin
                        if (colision_s) begin
                            vidas_q <= vidas_d;
                            if (vidas_d == 2'd0) begin
                                estado_q <= S_LOSE;
                                wl_q     <= 2'b01;
                            end else if (INVULN > 0) begin
                                estado_q <= S_INV;
                                inv_q    <= INV_LOAD;
                            end else begin
                                estado_q <= S_PLAY;
                            end
                        end else begin
                            puntaje_q <= puntaje_d;
                            if (bono_s) begin
                                bonos_q <= bonos_d;
                            end
                            if (bono_s && (bonos_d == BONOS_META)) begin
                                estado_q <= S_WIN;
                                wl_q     <= 2'b10;
                            end else if (estado_q == S_INV) begin
                                inv_q <= inv_d;
                                if (inv_d == {INV_W{1'b0}}) begin
                                    estado_q <= S_PLAY;
                                end
                            end
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    // Verdict and counters hold until the game is left.
                    estado_q <= estado_q;
                end
                default: begin
                    estado_q <= S_IDLE;
                    wl_q     <= 2'b00;
                end
            endcase
        end
    end

    assign W_or_L      = wl_q;
    assign bono_tomado = bono_q;
    assign vidas       = vidas_q;
    assign puntaje     = puntaje_q;

endmodule

// File: tb/tb_detector_colisiones.sv
// Self-checking bench for detector_colisiones: a cycle-indexed event model
// (evaluation queue, pulse time window) checked every cycle, plus literal
// expectations from hand-worked scenarios.
module tb_detector_colisiones;

    localparam logic [2:0] GAME = 3'd3;
    localparam int         BONO_PULSO = 4;
    localparam int         INVULN = 2;
    localparam int         META = 3;
    localparam int         VIDAS0 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] presente;
    logic       clk_obstaculos;
    logic [6:0] display_obs;
    logic [4:0] tipo_obs;
    logic [6:0] heroe;
    logic       accion;
    logic [1:0] W_or_L;
    logic       bono_tomado;
    logic [1:0] vidas;
    logic [7:0] puntaje;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    detector_colisiones #(
        .GAME(3'd3), .VIDAS_INI(2'd3), .INVULN(2), .BONOS_META(2'd3), .BONO_PULSO(4)
    ) dut (
        .clk(clk), .rst(rst), .presente(presente), .clk_obstaculos(clk_obstaculos),
        .display_obs(display_obs), .tipo_obs(tipo_obs), .heroe(heroe), .accion(accion),
        .W_or_L(W_or_L), .bono_tomado(bono_tomado), .vidas(vidas), .puntaje(puntaje)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Game states: 0 idle, 1 play, 2 invulnerable, 3 won, 4 lost.
    int  m_state, m_vidas, m_punt, m_bonos, m_inv;
    int  p_from, p_to;          // bono_tomado expected high for cycles p_from..p_to
    int  cyc;
    bit  m_prev, m_valid;
    int  evq[$];                // cycle numbers at which evaluations happen

    initial begin
        m_valid = 1'b0; cyc = 0; m_prev = 1'b0;
        m_state = 0; m_vidas = VIDAS0; m_punt = 0; m_bonos = 0; m_inv = 0;
        p_from = 0; p_to = -1;
        forever begin
            @(posedge clk);
            begin
                int  ended;
                bit  tick, jugando, hay_eval, coll;
                ended = cyc;
                if (rst) begin
                    m_state = 0; m_vidas = VIDAS0; m_punt = 0; m_bonos = 0; m_inv = 0;
                    p_to = -1; evq.delete(); m_prev = 1'b0; m_valid = 1'b1;
                end else begin
                    tick   = clk_obstaculos && !m_prev;
                    m_prev = clk_obstaculos;
                    if (presente != GAME) begin
                        m_state = 0; m_vidas = VIDAS0; m_punt = 0; m_bonos = 0; m_inv = 0;
                        p_to = -1; evq.delete();
                    end else begin
                        jugando  = (m_state == 1) || (m_state == 2);
                        hay_eval = (evq.size() > 0) && (evq[0] == ended);
                        if (hay_eval) void'(evq.pop_front());
                        if (m_state == 0) begin
                            m_state = 1; m_vidas = VIDAS0; m_punt = 0; m_bonos = 0; m_inv = 0;
                        end else if (hay_eval && jugando) begin
                            coll = (m_state == 1) && ((display_obs & heroe) != 0);
                            if (coll) begin
                                if (m_vidas > 0) m_vidas--;
                                if (m_vidas == 0) m_state = 4;
                                else begin m_state = 2; m_inv = INVULN; end
                            end else begin
                                if (display_obs != 0 && m_punt < 255) m_punt++;
                                if (m_state == 2) begin
                                    m_inv--;
                                    if (m_inv == 0) m_state = 1;
                                end
                                if (tipo_obs == 5'd16 && accion) begin
                                    m_bonos++;
                                    p_from = ended + 1;
                                    p_to   = ended + BONO_PULSO;
                                    if (m_bonos == META) m_state = 3;
                                end
                            end
                        end
                        if (tick && jugando) evq.push_back(ended + 2);
                    end
                end
                cyc = cyc + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("W_or_L", 32'(W_or_L), (m_state == 3) ? 32'd2 : (m_state == 4) ? 32'd1 : 32'd0);
                check("bono_tomado", 32'(bono_tomado), 32'((cyc >= p_from) && (cyc <= p_to)));
                check("vidas", 32'(vidas), 32'(m_vidas));
                check("puntaje", 32'(puntaje), 32'(m_punt));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One obstacle tick with the given inputs held; counts bono_tomado cycles after it.
    task automatic do_tick(input logic [6:0] d, input logic [4:0] t, input logic [6:0] h,
                           input logic a, output int hi);
        hi = 0;
        @(posedge clk); #1;
        display_obs = d; tipo_obs = t; heroe = h; accion = a; clk_obstaculos = 1'b1;
        @(posedge clk); #1;
        clk_obstaculos = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (bono_tomado) hi++;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int hi;
        rst = 1'b1; presente = 3'd0; clk_obstaculos = 1'b0;
        display_obs = 7'h00; tipo_obs = 5'd0; heroe = 7'h40; accion = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_vidas", 32'(vidas), 32'd3);
        check("reset_puntaje", 32'(puntaje), 32'd0);
        check("reset_wl", 32'(W_or_L), 32'd0);
        check("reset_bono", 32'(bono_tomado), 32'd0);

        // Five clean obstacles.
        presente = GAME;
        wait_cycles(3);
        for (int i = 0; i < 5; i++) do_tick(7'h08, 5'd0, 7'h40, 1'b0, hi);
        check("score5_puntaje", 32'(puntaje), 32'd5);
        check("score5_vidas", 32'(vidas), 32'd3);
        check("score5_wl", 32'(W_or_L), 32'd0);

        // Hit, then two ticks inside the invulnerability window, then a hit.
        do_tick(7'h40, 5'd0, 7'h40, 1'b0, hi);
        check("hit1_vidas", 32'(vidas), 32'd2);
        do_tick(7'h40, 5'd0, 7'h40, 1'b0, hi);
        do_tick(7'h40, 5'd0, 7'h40, 1'b0, hi);
        check("inv_vidas", 32'(vidas), 32'd2);
        do_tick(7'h40, 5'd0, 7'h40, 1'b0, hi);
        check("hit2_vidas", 32'(vidas), 32'd1);

        // Clear invulnerability, then final hit loses the game.
        do_tick(7'h08, 5'd0, 7'h40, 1'b0, hi);
        do_tick(7'h08, 5'd0, 7'h40, 1'b0, hi);
        do_tick(7'h40, 5'd0, 7'h40, 1'b0, hi);
        check("lose_vidas", 32'(vidas), 32'd0);
        check("lose_wl", 32'(W_or_L), 32'd1);
        do_tick(7'h40, 5'd0, 7'h40, 1'b0, hi);
        check("lose_hold_vidas", 32'(vidas), 32'd0);
        check("lose_hold_puntaje", 32'(puntaje), 32'd9);

        // Leaving the game from LOSE.
        presente = 3'd0;
        wait_cycles(2);
        @(negedge clk);
        check("idle_wl", 32'(W_or_L), 32'd0);
        check("idle_vidas", 32'(vidas), 32'd3);
        presente = GAME;
        wait_cycles(3);

        // Three bonuses win the game.
        for (int i = 0; i < 3; i++) begin
            do_tick(7'h00, 5'd16, 7'h40, 1'b1, hi);
            check("bonus_pulse_len", 32'(hi), 32'd4);
        end
        check("win_wl", 32'(W_or_L), 32'd2);

        // Bonus attempt with a collision: collision wins.
        presente = 3'd0;
        wait_cycles(2);
        presente = GAME;
        wait_cycles(3);
        do_tick(7'h40, 5'd16, 7'h40, 1'b1, hi);
        check("collbonus_vidas", 32'(vidas), 32'd2);
        check("collbonus_pulse", 32'(hi), 32'd0);

        // Score to 7, start a bonus pulse and reset in the middle of it.
        for (int i = 0; i < 7; i++) do_tick(7'h08, 5'd0, 7'h40, 1'b0, hi);
        check("pre_rst_puntaje", 32'(puntaje), 32'd7);
        @(posedge clk); #1;
        display_obs = 7'h00; tipo_obs = 5'd16; accion = 1'b1; clk_obstaculos = 1'b1;
        @(posedge clk); #1;
        clk_obstaculos = 1'b0;
        wait_cycles(2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_pulse_bono", 32'(bono_tomado), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_bono", 32'(bono_tomado), 32'd0);
        check("rst_puntaje", 32'(puntaje), 32'd0);
        check("rst_vidas", 32'(vidas), 32'd3);
        check("rst_wl", 32'(W_or_L), 32'd0);

        // Back-to-back bonuses: second restarts the pulse with no gap.
        wait_cycles(3);
        clk_obstaculos = 1'b1;
        @(posedge clk); #1; clk_obstaculos = 1'b0;
        @(posedge clk); #1; clk_obstaculos = 1'b1;
        @(posedge clk); #1; clk_obstaculos = 1'b0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bono_tomado) hi++;
        end
        check("restart_pulse_len", 32'(hi), 32'd6);
        check("restart_wl", 32'(W_or_L), 32'd0);

        presente = 3'd0; accion = 1'b0; tipo_obs = 5'd0;
        wait_cycles(3);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/detector_colisiones.md
DETECTOR_COLISIONES -- requirements
Module: detector_colisiones

Interface
REQ-001 Parameter GAME, default 3'd3: value of presente meaning game in progress.
REQ-002 Parameter VIDAS_INI, default 2'd3: lives loaded on game start.
REQ-003 Parameter INVULN, default 2: evaluations ignored for collision after a hit.
REQ-004 Parameter BONOS_META, default 2'd3: bonuses required to win.
REQ-005 Parameter BONO_PULSO, default 4: clk cycles bono_tomado stays high per bonus.
REQ-006 clk  in  1  system clock, only clock; all logic on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 presente  in  3  top-level game state.
REQ-009 clk_obstaculos  in  1  obstacle scroll tick (level signal generated in clk domain).
REQ-010 display_obs  in  7  segment pattern of the digit at the hero position (lowest obstacle digit).
REQ-011 tipo_obs  in  5  current obstacle type; 5'd16 = bonus window.
REQ-012 heroe  in  7  hero segment pattern (stance).
REQ-013 accion  in  1  player grab button, level.
REQ-014 W_or_L  out  2  00 playing/idle, 01 lost, 10 won.
REQ-015 bono_tomado  out  1  bonus-taken pulse to obstacle generator.
REQ-016 vidas  out  2  remaining lives.
REQ-017 puntaje  out  8  obstacles cleared.

Function
REQ-018 Tick detection: register clk_obstaculos once; tick = current 1 and registered 0 (one-cycle strobe).
REQ-019 Evaluation occurs exactly 2 clk cycles after the tick strobe, using display_obs, tipo_obs, heroe, accion sampled in that cycle.
REQ-020 States: IDLE, PLAY, INV, WIN, LOSE.
REQ-021 IDLE: W_or_L=00; on presente==GAME -> PLAY with vidas=VIDAS_INI, puntaje=0, bonus count=0, invuln count=0.
REQ-022 Any state: presente!=GAME -> IDLE next cycle, outputs return to reset values; overrides all other transitions.
REQ-023 PLAY evaluation, collision = (display_obs & heroe) != 0.
REQ-024 Collision: vidas decremented; if result 0 -> LOSE, else -> INV with invuln count=INVULN.
REQ-025 No collision and display_obs != 0: puntaje += 1, saturating at 255.
REQ-026 Bonus: tipo_obs==5'd16 and accion==1 and no collision -> bonus count += 1 and bono_tomado high for BONO_PULSO cycles starting the cycle after evaluation.
REQ-027 Bonus count reaching BONOS_META -> WIN in the same update; puntaje still updates.
REQ-028 Collision and bonus conditions in one evaluation: collision wins, bonus ignored.
REQ-029 INV: each evaluation decrements invuln count, no collision check, scoring and bonus rules still apply; count reaching 0 -> PLAY.
REQ-030 WIN: W_or_L=10; LOSE: W_or_L=01; both hold, vidas/puntaje frozen, until presente!=GAME or rst.
REQ-031 A bonus pulse in progress completes its BONO_PULSO cycles even if state changes to WIN; a new bonus during a pulse restarts the count (no gap).
REQ-032 Ticks arriving in IDLE, WIN, LOSE produce no evaluation effects.
REQ-033 vidas never underflows; decrement only when vidas != 0.

Reset
REQ-034 rst==1 at posedge clk: state=IDLE, W_or_L=00, bono_tomado=0, vidas=VIDAS_INI, puntaje=0, bonus count=0, invuln count=0, tick register=0, pending evaluation cancelled.
REQ-035 rst mid-game or mid-pulse: same values next cycle; bono_tomado drops immediately.
REQ-036 rst has priority over every other event.

Verification
REQ-037 presente=GAME, 5 ticks with display_obs=7'h08, heroe=7'h40 -> puntaje=5, vidas=3, W_or_L=00.
REQ-038 PLAY, tick with display_obs=7'h40, heroe=7'h40 -> vidas=2, state INV; next 2 overlapping ticks -> vidas stays 2; third -> vidas=1.
REQ-039 vidas=1, overlapping tick -> vidas=0, W_or_L=01; further ticks -> no change.
REQ-040 Three ticks with tipo_obs=16, display_obs=0, accion=1 -> bono_tomado 4-cycle pulse each, W_or_L=10 after third.
REQ-041 tipo_obs=16, accion=1, display_obs&heroe!=0 -> vidas decrements, no bono_tomado pulse.
REQ-042 rst during bonus pulse, puntaje=7 -> next cycle bono_tomado=0, puntaje=0, vidas=3, W_or_L=00; presente!=GAME from LOSE -> IDLE, W_or_L=00.
